// File: rtl/alu_pkg.sv
// Shared constants and types for the unsigned divide/modulus unit.
package alu_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MOD = 1'b1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference or restore.
module div_step #(
  parameter int W = alu_pkg::WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] dsr_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;

  assign shifted = {rem_i, dvd_msb_i};
  // One extra bit so the borrow is visible even when shifted >= 2^W.
  assign diff    = {1'b0, shifted} - {2'b00, dsr_i};
  assign q_o     = ~diff[W+1];
  // rem_i < dsr_i always holds, so a kept difference fits in W bits.
  assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle unsigned divider returning quotient or remainder, one
// quotient bit per clock, with divide-by-zero short-circuit.
module alu_div_unit #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err_dz,
  output alu_pkg::state_e      state_o
);
  import alu_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 op_q, op_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     quo_next;

  div_step #(.W(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // The dividend register doubles as the quotient accumulator.
  assign quo_next = {dvd_q[WIDTH-2:0], step_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            state_d  = DONE;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d = RUN;
            dvd_d   = a;
            dsr_d   = b;
            op_d    = op;
            rem_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = (op_q == OP_MOD) ? {{WIDTH{1'b0}}, step_rem}
                                      : {{WIDTH{1'b0}}, quo_next};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      op_q     <= OP_DIV;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign err_dz  = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// Scoreboard bench for alu_div_unit: expected {err_dz, result} and done
// cycle are queued at start and checked when done pulses.
module tb_alu_div_unit;
  import alu_pkg::*;

  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              op;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              busy;
  logic              done;
  logic [2*W-1:0]    result;
  logic              err_dz;
  state_e            dbg_state;

  logic [2*W:0]      exp_q[$];
  int                lat_q[$];
  logic [2*W-1:0]    last_res;
  logic              idle_chk;
  int                cyc;
  int                n_tests;
  int                n_fail;

  alu_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err_dz  (err_dz),
    .state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin : mon
    logic [2*W:0] e;
    int           l;
    if (idle_chk) begin
      chk("busy_after_done", busy, 0);
      idle_chk = 1'b0;
    end
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("result", result, e[2*W-1:0]);
        chk("err_dz", err_dz, e[2*W]);
        chk("latency", cyc, l);
        last_res = e[2*W-1:0];
        idle_chk = 1'b1;
      end
    end
  end

  // Driver tasks
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top);
    logic [2*W:0] e;
    if (tb == 0)  e = {1'b1, {(2*W){1'b0}}};
    else if (top) e = {1'b0, {W{1'b0}}, ta % tb};
    else          e = {1'b0, {W{1'b0}}, ta / tb};
    exp_q.push_back(e);
    lat_q.push_back(cyc + ((tb == 0) ? 1 : 17));
    a = ta;
    b = tb;
    op = top;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_on_accept", busy, 1);
    if (tb != 0) begin
      chk("err_clr", err_dz, 0);
      chk("res_hold", result, last_res);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("timeout", 0, 1);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    cyc = 0;
    n_tests = 0;
    n_fail = 0;
    idle_chk = 1'b0;
    last_res = '0;
    rst = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err_dz, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_op(16'd100, 16'd7, OP_DIV);   wait_idle();
    start_op(16'd100, 16'd7, OP_MOD);   wait_idle();
    start_op(16'hFFFF, 16'd1, OP_DIV);  wait_idle();
    start_op(16'hFFFF, 16'hFFFF, OP_MOD); wait_idle();
    start_op(16'd5, 16'd0, OP_DIV);     wait_idle();
    start_op(16'd8, 16'd3, OP_MOD);     wait_idle();
    start_op(16'd3, 16'd10, OP_DIV);    wait_idle();
    start_op(16'd3, 16'd10, OP_MOD);    wait_idle();
    start_op(16'd0, 16'd5, OP_DIV);     wait_idle();
    start_op(16'd0, 16'd5, OP_MOD);     wait_idle();

    // Start while running must be ignored; operands changed after acceptance.
    start_op(16'd40, 16'd6, OP_DIV);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; a = 16'd9; b = 16'd3; op = OP_MOD;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'd77; b = 16'd0;
    wait_idle();

    // Start during the DONE cycle must be ignored.
    start_op(16'd50, 16'd7, OP_MOD);
    repeat (16) @(posedge clk);
    #1;
    chk("done_cycle", done, 1);
    start = 1'b1; a = 16'd1; b = 16'd1; op = OP_DIV;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    wait_idle();

    // Reset mid-run aborts with no done pulse.
    start_op(16'd1000, 16'd10, OP_DIV);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    last_res = '0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    chk("abort_state", dbg_state, IDLE);
    repeat (20) @(posedge clk);
    #1;
    start_op(16'd1000, 16'd10, OP_DIV); wait_idle();

    for (int i = 0; i < 24; i++) begin
      ra  = W'($urandom_range(0, 65535));
      if (i % 7 == 3)      rb = '0;
      else if (i % 3 == 0) rb = W'($urandom_range(1, 15));
      else                 rb = W'($urandom_range(1, 65535));
      rop = 1'($urandom_range(0, 1));
      start_op(ra, rb, rop);
      wait_idle();
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
